// File: rtl/ex_branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_branch_resolve_stage
// Brief    : EX->MEM slice that resolves branches/JAL from the ALU condition
//            bit, issues a redirect plus timed front-end flush, and forwards the
//            result through a 2-entry skid-buffered valid/ready register slice.
//            Optional macro BR_STATS_EN adds branch/taken statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module ex_branch_resolve_stage #(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            in_is_branch,
    input  logic            in_is_jal,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_wr_en,
    input  logic            in_mem_rd,
    input  logic            in_mem_wr,
    input  logic [XLEN-1:0] in_store_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd_addr,
    output logic            out_wr_en,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [XLEN-1:0] out_store_data,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_o
`ifdef BR_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     br_taken_count
`endif
);

    localparam logic [XLEN-1:0] c_PC_STEP  = XLEN'(4);
    localparam int              c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd_addr;
        logic            wr_en;
        logic            mem_rd;
        logic            mem_wr;
        logic [XLEN-1:0] store_data;
    } entry_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_t             r_main_q,        w_main_d;
    logic               r_main_valid_q,  w_main_valid_d;
    entry_t             r_skid_q,        w_skid_d;
    logic               r_skid_valid_q,  w_skid_valid_d;
    state_t             r_state_q,       w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,         w_cnt_d;
    logic               r_redirect_q,    w_redirect_d;
    logic [XLEN-1:0]    r_redirect_pc_q, w_redirect_pc_d;
    logic               r_flush_q,       w_flush_d;

    // ------------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------------
    logic   w_accept;
    logic   w_store;
    logic   w_cond_branch;
    logic   w_taken;
    entry_t w_new;

    assign in_ready      = ~r_skid_valid_q;
    assign w_accept      = in_valid & in_ready;
    // Accepts while flushing are wrong-path: consumed but never stored.
    assign w_store       = w_accept & (r_state_q == S_RUN);
    assign w_cond_branch = in_is_branch & ~in_is_jal;
    assign w_taken       = in_is_jal | (in_is_branch & in_alu_result[0]);

    always_comb begin
        w_new            = '0;
        w_new.result     = in_is_jal ? (in_pc + c_PC_STEP) : in_alu_result;
        w_new.rd_addr    = in_rd_addr;
        w_new.wr_en      = in_wr_en  & ~w_cond_branch;
        w_new.mem_rd     = in_mem_rd & ~w_cond_branch;
        w_new.mem_wr     = in_mem_wr & ~w_cond_branch;
        w_new.store_data = in_store_data;
    end

    // ------------------------------------------------------------------------
    // Skid-buffered register slice
    // ------------------------------------------------------------------------
    always_comb begin
        w_main_d       = r_main_q;
        w_main_valid_d = r_main_valid_q;
        w_skid_d       = r_skid_q;
        w_skid_valid_d = r_skid_valid_q;

        if (!r_main_valid_q || out_ready) begin
            // Main entry is free (or leaving): skid has priority to keep order.
            if (r_skid_valid_q) begin
                w_main_d       = r_skid_q;
                w_main_valid_d = 1'b1;
                w_skid_valid_d = 1'b0;
            end else if (w_store) begin
                w_main_d       = w_new;
                w_main_valid_d = 1'b1;
            end else begin
                w_main_valid_d = 1'b0;
            end
        end else if (w_store) begin
            w_skid_d       = w_new;
            w_skid_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Redirect / flush control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d       = r_state_q;
        w_cnt_d         = r_cnt_q;
        w_redirect_d    = 1'b0;
        w_redirect_pc_d = r_redirect_pc_q;
        w_flush_d       = r_flush_q;

        case (r_state_q)
            S_RUN: begin
                if (w_store && w_taken) begin
                    w_redirect_d    = 1'b1;
                    w_redirect_pc_d = in_pc + in_imm;
                    w_state_d       = S_FLUSH;
                    w_cnt_d         = c_CNT_INIT;
                    w_flush_d       = 1'b1;
                end
            end
            S_FLUSH: begin
                if (r_cnt_q == '0) begin
                    w_state_d = S_RUN;
                    w_flush_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            default: begin
                w_state_d = S_RUN;
                w_flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_q        <= '0;
            r_main_valid_q  <= 1'b0;
            r_skid_q        <= '0;
            r_skid_valid_q  <= 1'b0;
            r_state_q       <= S_RUN;
            r_cnt_q         <= '0;
            r_redirect_q    <= 1'b0;
            r_redirect_pc_q <= '0;
            r_flush_q       <= 1'b0;
        end else begin
            r_main_q        <= w_main_d;
            r_main_valid_q  <= w_main_valid_d;
            r_skid_q        <= w_skid_d;
            r_skid_valid_q  <= w_skid_valid_d;
            r_state_q       <= w_state_d;
            r_cnt_q         <= w_cnt_d;
            r_redirect_q    <= w_redirect_d;
            r_redirect_pc_q <= w_redirect_pc_d;
            r_flush_q       <= w_flush_d;
        end
    end

    assign out_valid      = r_main_valid_q;
    assign out_result     = r_main_q.result;
    assign out_rd_addr    = r_main_q.rd_addr;
    assign out_wr_en      = r_main_q.wr_en;
    assign out_mem_rd     = r_main_q.mem_rd;
    assign out_mem_wr     = r_main_q.mem_wr;
    assign out_store_data = r_main_q.store_data;
    assign redirect_o     = r_redirect_q;
    assign redirect_pc    = r_redirect_pc_q;
    assign flush_o        = r_flush_q;

    // ------------------------------------------------------------------------
    // Optional branch statistics
    // ------------------------------------------------------------------------
`ifdef BR_STATS_EN
    logic [31:0] r_br_count_q,       w_br_count_d;
    logic [31:0] r_br_taken_count_q, w_br_taken_count_d;

    always_comb begin
        w_br_count_d       = r_br_count_q;
        w_br_taken_count_d = r_br_taken_count_q;
        if (w_store && (in_is_branch || in_is_jal)) begin
            w_br_count_d = r_br_count_q + 32'd1;
            if (w_taken) begin
                w_br_taken_count_d = r_br_taken_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count_q       <= '0;
            r_br_taken_count_q <= '0;
        end else begin
            r_br_count_q       <= w_br_count_d;
            r_br_taken_count_q <= w_br_taken_count_d;
        end
    end

    assign br_count       = r_br_count_q;
    assign br_taken_count = r_br_taken_count_q;
`endif

endmodule
`default_nettype wire
